// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory arbiter.
// Latency: n/a (types and helper function only).
// Backpressure: n/a.
//
// Contents:
//   STATE_W  - width of the arbiter state register
//   state_e  - arbiter FSM states
//   STAT_W   - width of the optional statistics counters
//   sat_inc  - saturating increment used by the statistics counters
package mem_arb_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 3'd0,
        BUSY_I = 3'd1,
        BUSY_D = 3'd2,
        RESP_I = 3'd3,
        RESP_D = 3'd4
    } state_e;

    localparam int STAT_W = 32;

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : (v + STAT_W'(1));
    endfunction

endpackage

// File: rtl/mem_arb_stats.sv
// Saturating activity counters for the memory arbiter (conflicts, busy cycles).
// Latency: counters update one cycle after the sampled event.
// Backpressure: none; pure observers, never stall the arbiter.
//
// Ports:
//   clk, rst_n         - clock, synchronous active-low reset
//   conflict_i         - arbiter idle with both requesters asking this cycle
//   busy_i             - shared memory port has mem_req high this cycle
//   stat_conflict_o    - count of conflict cycles, saturating
//   stat_busy_o        - count of busy cycles, saturating
module mem_arb_stats
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              conflict_i,
    input  logic              busy_i,
    output logic [STAT_W-1:0] stat_conflict_o,
    output logic [STAT_W-1:0] stat_busy_o
);

    logic [STAT_W-1:0] conflict_q, conflict_d;
    logic [STAT_W-1:0] busy_q, busy_d;

    always_comb begin
        conflict_d = conflict_i ? sat_inc(conflict_q) : conflict_q;
        busy_d     = busy_i     ? sat_inc(busy_q)     : busy_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            conflict_q <= '0;
            busy_q     <= '0;
        end else begin
            conflict_q <= conflict_d;
            busy_q     <= busy_d;
        end
    end

    assign stat_conflict_o = conflict_q;
    assign stat_busy_o     = busy_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (fetch, data) arbiter onto one shared single-outstanding memory port.
// Latency: grant 1 cycle after req; ack 1 cycle after mem_ack; back in IDLE the cycle after ack.
// Backpressure: requesters hold req until their ack pulse; losers wait while the port is busy.
//
// Ports:
//   clk, rst_n                              - clock, synchronous active-low reset
//   if_req/if_addr -> if_ack/if_rdata       - instruction fetch (read only)
//   d_req/d_addr/d_write/d_byte/d_wdata
//                  -> d_ack/d_rdata         - data load/store, word or byte
//   mem_req/mem_addr/mem_we/mem_byte/mem_wdata,
//   mem_ack/mem_rdata                       - shared memory port, any latency >= 1
//   stat_conflict, stat_busy                - only when MEM_ARB_STATS_EN is defined
//
// Build option: define MEM_ARB_STATS_EN to add the saturating statistics counters.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32   // byte-load zero extension assumes a 32-bit word
)(
    input  logic              clk,
    input  logic              rst_n,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_write,
    input  logic              d_byte,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,

    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_byte,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_conflict,
    output logic [STAT_W-1:0] stat_busy
`endif
);

    state_e            state_q, state_d;
    logic              last_d_q, last_d_d;     // 1 = data was the most recent grant
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic              byte_q, byte_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

    logic grant_d;
    logic grant_i;
    logic busy;

    // Data wins unless fetch is also asking and data had the last turn.
    assign grant_d = d_req && (!if_req || !last_d_q);
    assign grant_i = if_req && !grant_d;

    always_comb begin
        state_d    = state_q;
        last_d_d   = last_d_q;
        addr_d     = addr_q;
        we_d       = we_q;
        byte_d     = byte_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d  = BUSY_D;
                    last_d_d = 1'b1;
                    addr_d   = d_addr;
                    we_d     = d_write;
                    byte_d   = d_byte;
                    wdata_d  = d_wdata;
                end else if (grant_i) begin
                    state_d  = BUSY_I;
                    last_d_d = 1'b0;
                    addr_d   = if_addr;
                    we_d     = 1'b0;
                    byte_d   = 1'b0;
                    wdata_d  = '0;
                end
            end

            BUSY_I: begin
                if (mem_ack) begin
                    if_rdata_d = mem_rdata;
                    state_d    = RESP_I;
                end
            end

            BUSY_D: begin
                if (mem_ack) begin
                    // Stores return zero so a stale load value never leaks out with d_ack.
                    if (we_q) begin
                        d_rdata_d = '0;
                    end else if (byte_q) begin
                        d_rdata_d = {{(DATA_W-8){1'b0}}, mem_rdata[7:0]};
                    end else begin
                        d_rdata_d = mem_rdata;
                    end
                    state_d = RESP_D;
                end
            end

            // Single ack cycle; requests and stray mem_ack are ignored here.
            RESP_I:  state_d = IDLE;
            RESP_D:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_d_q   <= 1'b0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            byte_q     <= 1'b0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_d_q   <= last_d_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            byte_q     <= byte_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign busy = (state_q == BUSY_I) || (state_q == BUSY_D);

    // Strobes are qualified with busy so a finished store does not leave mem_we
    // asserted on an idle port; address and write data are straight from the registers.
    assign mem_req   = busy;
    assign mem_addr  = addr_q;
    assign mem_we    = we_q & busy;
    assign mem_byte  = byte_q & busy;
    assign mem_wdata = wdata_q;

    assign if_ack    = (state_q == RESP_I);
    assign d_ack     = (state_q == RESP_D);
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

`ifdef MEM_ARB_STATS_EN
    mem_arb_stats u_stats (
        .clk             (clk),
        .rst_n           (rst_n),
        .conflict_i      ((state_q == IDLE) && if_req && d_req),
        .busy_i          (busy),
        .stat_conflict_o (stat_conflict),
        .stat_busy_o     (stat_busy)
    );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req;
    logic [31:0] d_addr;
    logic        d_write;
    logic        d_byte;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic        mem_byte;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
`ifdef MEM_ARB_STATS_EN
    logic [31:0] stat_conflict;
    logic [31:0] stat_busy;
`endif

    int n_chk;
    int n_pass;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_addr    (d_addr),
        .d_write   (d_write),
        .d_byte    (d_byte),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_byte  (mem_byte),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
`ifdef MEM_ARB_STATS_EN
        ,
        .stat_conflict (stat_conflict),
        .stat_busy     (stat_busy)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        if_req = 1'b1;
        d_req  = 1'b1;
        if_addr = 32'hAAAA_0000;
        d_addr  = 32'hBBBB_0000;
        d_write = 1'b1;
        d_wdata = 32'h1234_5678;
        tick();
        tick();
        n_chk++; if (mem_req !== 1'b0) $display("FAIL rst_mem_req: got %h want 0", mem_req); else n_pass++;
        n_chk++; if (mem_addr !== 32'h0) $display("FAIL rst_mem_addr: got %h want 0", mem_addr); else n_pass++;
        n_chk++; if (mem_we !== 1'b0 || mem_byte !== 1'b0) $display("FAIL rst_mem_we_byte: got %b%b want 00", mem_we, mem_byte); else n_pass++;
        n_chk++; if (mem_wdata !== 32'h0) $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); else n_pass++;
        n_chk++; if (if_ack !== 1'b0 || d_ack !== 1'b0) $display("FAIL rst_acks: got %b%b want 00", if_ack, d_ack); else n_pass++;
        n_chk++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) $display("FAIL rst_rdata: got %h %h want 0 0", if_rdata, d_rdata); else n_pass++;
`ifdef MEM_ARB_STATS_EN
        n_chk++; if (stat_conflict !== 32'h0 || stat_busy !== 32'h0) $display("FAIL rst_stats: got %0d %0d want 0 0", stat_conflict, stat_busy); else n_pass++;
`endif
        if_req  = 1'b0;
        d_req   = 1'b0;
        d_write = 1'b0;
        rst_n   = 1'b1;
        tick();
        n_chk++; if (mem_req !== 1'b0) $display("FAIL rst_idle_after: got %h want 0", mem_req); else n_pass++;
    endtask

    task automatic test_fetch();
        if_addr = 32'h0000_0100;
        if_req  = 1'b1;
        tick();                                   // cycle 1: BUSY_I
        n_chk++; if (mem_req !== 1'b1) $display("FAIL fetch_mem_req: got %h want 1", mem_req); else n_pass++;
        n_chk++; if (mem_addr !== 32'h100) $display("FAIL fetch_mem_addr: got %h want 100", mem_addr); else n_pass++;
        n_chk++; if (mem_we !== 1'b0 || mem_byte !== 1'b0) $display("FAIL fetch_we_byte: got %b%b want 00", mem_we, mem_byte); else n_pass++;
        tick();
        tick();                                   // cycle 3
        n_chk++; if (mem_req !== 1'b1 || if_ack !== 1'b0) $display("FAIL fetch_wait: got req=%b ack=%b want 1 0", mem_req, if_ack); else n_pass++;
        tick();                                   // cycle 4: memory answers
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        tick();                                   // cycle 5: RESP_I
        n_chk++; if (if_ack !== 1'b1) $display("FAIL fetch_ack: got %h want 1", if_ack); else n_pass++;
        n_chk++; if (if_rdata !== 32'hDEAD_BEEF) $display("FAIL fetch_rdata: got %h want deadbeef", if_rdata); else n_pass++;
        n_chk++; if (mem_req !== 1'b0 || d_ack !== 1'b0) $display("FAIL fetch_resp_req: got req=%b d_ack=%b want 0 0", mem_req, d_ack); else n_pass++;
        if_req    = 1'b0;
        mem_rdata = 32'h1234_5678;                // mem_ack left high: must be ignored
        tick();                                   // cycle 6: IDLE
        n_chk++; if (if_ack !== 1'b0) $display("FAIL fetch_ack_one_cycle: got %h want 0", if_ack); else n_pass++;
        n_chk++; if (if_rdata !== 32'hDEAD_BEEF) $display("FAIL fetch_rdata_hold: got %h want deadbeef", if_rdata); else n_pass++;
        tick();
        n_chk++; if (mem_req !== 1'b0 || if_ack !== 1'b0 || d_ack !== 1'b0) $display("FAIL idle_ack_ignored: got req=%b if_ack=%b d_ack=%b want 0 0 0", mem_req, if_ack, d_ack); else n_pass++;
        mem_ack = 1'b0;
    endtask

    task automatic test_byte_load();
        d_addr  = 32'h0000_0204;
        d_write = 1'b0;
        d_byte  = 1'b1;
        d_req   = 1'b1;
        tick();
        n_chk++; if (mem_req !== 1'b1 || mem_addr !== 32'h204) $display("FAIL bload_grant: got req=%b addr=%h want 1 204", mem_req, mem_addr); else n_pass++;
        n_chk++; if (mem_byte !== 1'b1 || mem_we !== 1'b0) $display("FAIL bload_byte_we: got %b%b want 10", mem_byte, mem_we); else n_pass++;
        tick();
        mem_ack   = 1'b1;
        mem_rdata = 32'h1122_3344;
        tick();
        mem_ack = 1'b0;
        n_chk++; if (d_ack !== 1'b1) $display("FAIL bload_ack: got %h want 1", d_ack); else n_pass++;
        n_chk++; if (d_rdata !== 32'h0000_0044) $display("FAIL bload_rdata: got %h want 00000044", d_rdata); else n_pass++;
        d_req  = 1'b0;
        d_byte = 1'b0;
        tick();
        n_chk++; if (d_ack !== 1'b0 || d_rdata !== 32'h0000_0044) $display("FAIL bload_after: got ack=%b rdata=%h want 0 00000044", d_ack, d_rdata); else n_pass++;
    endtask

    task automatic test_store();
        d_addr  = 32'h0000_0208;
        d_write = 1'b1;
        d_byte  = 1'b0;
        d_wdata = 32'hCAFE_F00D;
        d_req   = 1'b1;
        tick();
        d_wdata = 32'h0;                          // port must keep the registered value
        for (int i = 0; i < 3; i++) begin
            n_chk++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'hCAFE_F00D) $display("FAIL store_hold_%0d: got req=%b we=%b wdata=%h want 1 1 cafef00d", i, mem_req, mem_we, mem_wdata); else n_pass++;
            if (i < 2) tick();
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        tick();
        mem_ack = 1'b0;
        n_chk++; if (d_ack !== 1'b1) $display("FAIL store_ack: got %h want 1", d_ack); else n_pass++;
        n_chk++; if (d_rdata !== 32'h0) $display("FAIL store_rdata: got %h want 0", d_rdata); else n_pass++;
        d_req   = 1'b0;
        d_write = 1'b0;
        tick();
        n_chk++; if (d_ack !== 1'b0 || mem_req !== 1'b0) $display("FAIL store_after: got ack=%b req=%b want 0 0", d_ack, mem_req); else n_pass++;
    endtask

    task automatic test_reset_mid();
        d_addr  = 32'h0000_020C;
        d_write = 1'b0;
        d_byte  = 1'b0;
        d_req   = 1'b1;
        tick();
        n_chk++; if (mem_req !== 1'b1) $display("FAIL rmid_busy: got %h want 1", mem_req); else n_pass++;
        rst_n = 1'b0;
        tick();
        n_chk++; if (mem_req !== 1'b0 || mem_addr !== 32'h0) $display("FAIL rmid_abandon: got req=%b addr=%h want 0 0", mem_req, mem_addr); else n_pass++;
        rst_n     = 1'b1;
        d_req     = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h0000_0077;
        tick();
        n_chk++; if (d_ack !== 1'b0 || mem_req !== 1'b0) $display("FAIL rmid_no_ack: got ack=%b req=%b want 0 0", d_ack, mem_req); else n_pass++;
        tick();
        n_chk++; if (d_ack !== 1'b0 || d_rdata !== 32'h0) $display("FAIL rmid_no_ack2: got ack=%b rdata=%h want 0 0", d_ack, d_rdata); else n_pass++;
        mem_ack = 1'b0;
        if_addr = 32'h0000_0500;
        if_req  = 1'b1;
        tick();
        n_chk++; if (mem_req !== 1'b1 || mem_addr !== 32'h500) $display("FAIL rmid_idle_regrant: got req=%b addr=%h want 1 500", mem_req, mem_addr); else n_pass++;
        mem_ack = 1'b1;
        tick();
        if_req  = 1'b0;
        mem_ack = 1'b0;
        tick();
    endtask

    // Both masters keep re-requesting; grants must go D, I, D, I.
    // Memory latencies 1..4 give 10 busy cycles and 4 idle conflict cycles.
    task automatic test_conflict();
        logic exp_d;
        rst_n = 1'b0;
        tick();
        rst_n   = 1'b1;
        if_addr = 32'h0000_0400;
        d_addr  = 32'h0000_0300;
        d_write = 1'b0;
        d_byte  = 1'b0;
        if_req  = 1'b1;
        d_req   = 1'b1;
        tick();
        for (int g = 0; g < 4; g++) begin
            exp_d = (g % 2 == 0);
            n_chk++; if (mem_req !== 1'b1 || mem_addr !== (exp_d ? 32'h300 : 32'h400)) $display("FAIL conflict_grant_%0d: got req=%b addr=%h want 1 %h", g, mem_req, mem_addr, exp_d ? 32'h300 : 32'h400); else n_pass++;
            repeat (g) tick();
            mem_ack   = 1'b1;
            mem_rdata = 32'h0000_1000 + g;
            tick();
            mem_ack = 1'b0;
            if (exp_d) begin
                n_chk++; if (d_ack !== 1'b1 || if_ack !== 1'b0 || d_rdata !== 32'h0000_1000 + g) $display("FAIL conflict_dack_%0d: got d_ack=%b if_ack=%b rdata=%h want 1 0 %h", g, d_ack, if_ack, d_rdata, 32'h0000_1000 + g); else n_pass++;
                d_req = 1'b0;
            end else begin
                n_chk++; if (if_ack !== 1'b1 || d_ack !== 1'b0 || if_rdata !== 32'h0000_1000 + g) $display("FAIL conflict_iack_%0d: got if_ack=%b d_ack=%b rdata=%h want 1 0 %h", g, if_ack, d_ack, if_rdata, 32'h0000_1000 + g); else n_pass++;
                if_req = 1'b0;
            end
            if (g == 3) begin
                if_req = 1'b0;
                d_req  = 1'b0;
            end
            tick();
            if (g < 3) begin
                if (exp_d) d_req = 1'b1;
                else       if_req = 1'b1;
            end
            tick();
        end
        n_chk++; if (mem_req !== 1'b0) $display("FAIL conflict_end_idle: got %h want 0", mem_req); else n_pass++;
`ifdef MEM_ARB_STATS_EN
        n_chk++; if (stat_conflict !== 32'd4) $display("FAIL stat_conflict: got %0d want 4", stat_conflict); else n_pass++;
        n_chk++; if (stat_busy !== 32'd10) $display("FAIL stat_busy: got %0d want 10", stat_busy); else n_pass++;
`endif
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        if_req    = 1'b0;
        if_addr   = 32'h0;
        d_req     = 1'b0;
        d_addr    = 32'h0;
        d_write   = 1'b0;
        d_byte    = 1'b0;
        d_wdata   = 32'h0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;

        test_reset();
        test_fetch();
        test_byte_load();
        test_store();
        test_reset_mid();
        test_conflict();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
